// File: rtl/module_monitor_reloj.sv
// Frequency/activity monitor: counts synchronized rising edges of sig_in over a
// fixed gate window of clk cycles and flags whether the count is in range.
module module_monitor_reloj #(
  parameter int GATE_CYCLES = 100_000,
  parameter int CNT_W       = 17,
  parameter int EXP_MIN     = 9_990,
  parameter int EXP_MAX     = 10_010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] count_out,
  output logic             valid,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       led
);

  localparam int                GATE_W    = $clog2(GATE_CYCLES + 1);
  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(EXP_MAX);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    EVAL
  } state_t;

  state_t              state_q, state_d;
  logic                s1_q, s2_q, s3_q;
  logic                rise;
  logic                in_range;
  logic [GATE_W-1:0]   gate_q, gate_d;
  logic [CNT_W-1:0]    edges_q, edges_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                valid_q, valid_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic [1:0]          led_q, led_d;

  assign rise     = s2_q & ~s3_q;
  assign in_range = (edges_q >= MIN_C) && (edges_q <= MAX_C);

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    edges_d = edges_q;
    count_d = count_q;
    valid_d = 1'b0;
    pass_d  = pass_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = MEASURE;
          gate_d  = GATE_LOAD;
          edges_d = '0;
        end
      end
      MEASURE: begin
        // Dropping en abandons the window; the published results stay untouched.
        if (!en) begin
          state_d = IDLE;
          edges_d = '0;
        end else begin
          if (rise && (edges_q != CNT_MAX)) begin
            edges_d = edges_q + 1'b1;
          end
          if (gate_q == '0) begin
            state_d = EVAL;
          end else begin
            gate_d = gate_q - 1'b1;
          end
        end
      end
      EVAL: begin
        count_d = edges_q;
        valid_d = 1'b1;
        pass_d  = in_range;
        fail_d  = ~in_range;
        if (en) begin
          state_d = MEASURE;
          gate_d  = GATE_LOAD;
          edges_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    led_d = {fail_d, pass_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      gate_q  <= '0;
      edges_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      led_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      s1_q    <= sig_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      gate_q  <= gate_d;
      edges_q <= edges_d;
      count_q <= count_d;
      valid_q <= valid_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      led_q   <= led_d;
    end
  end

  assign count_out = count_q;
  assign valid     = valid_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign led       = led_q;

endmodule

// File: tb/tb_module_monitor_reloj.sv
// Bench for module_monitor_reloj: table windows, hand-built corner sequences and
// random waveforms checked against a sample-history edge-count model.
module tb_module_monitor_reloj;

  localparam int G   = 100;
  localparam int W   = 8;
  localparam int WS  = 4;
  localparam int MN  = 9;
  localparam int MX  = 11;
  localparam int SMX = (1 << WS) - 1;
  localparam int HN  = 16384;

  typedef struct {
    int       mode;
    int       period;
    int       exp_cnt;
    bit       exp_pass;
    bit [1:0] exp_led;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          sig_in;
  logic [W-1:0]  count_out;
  logic          valid, pass, fail;
  logic [1:0]    led;
  logic [WS-1:0] count_s;
  logic          valid_s, pass_s, fail_s;
  logic [1:0]    led_s;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  bit hist [0:HN-1];

  int mode = 0;
  int period = 10;
  int ph = 0;
  int run_left = 2;
  int last_cnt = 0;
  bit last_pass = 1'b0;
  bit last_fail = 1'b0;

  vec_t tbl [8];

  always #5 clk = ~clk;

  module_monitor_reloj #(.GATE_CYCLES(G), .CNT_W(W), .EXP_MIN(MN), .EXP_MAX(MX)) dut (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .count_out(count_out), .valid(valid), .pass(pass), .fail(fail), .led(led)
  );

  // Narrow-counter copy driven identically, so saturation is reachable.
  module_monitor_reloj #(.GATE_CYCLES(G), .CNT_W(WS), .EXP_MIN(MN), .EXP_MAX(MX)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .count_out(count_s), .valid(valid_s), .pass(pass_s), .fail(fail_s), .led(led_s)
  );

  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (edge_n < HN) hist[edge_n] = sig_in;
  end

  task automatic nextSig();
    case (mode)
      0: sig_in = 1'b0;
      1: sig_in = 1'b1;
      2: begin
        ph = (ph + 1) % period;
        sig_in = (ph < period / 2);
      end
      default: begin
        run_left = run_left - 1;
        if (run_left <= 0) begin
          sig_in = ~sig_in;
          run_left = $urandom_range(2, 7);
        end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    nextSig();
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Rising transitions between consecutive clk samples that land in the window
  // opened at edge e, allowing for the three-cycle input latency.
  function automatic int modelCount(input int e);
    int c = 0;
    for (int j = e - 2; j <= e + G - 3; j++) begin
      if (j >= 0 && j + 1 < HN && !hist[j] && hist[j + 1]) c++;
    end
    return c;
  endfunction

  task automatic checkOutput(input string name, input int cnt, input bit p, input bit [1:0] l);
    int  sc;
    bit  sp;
    sc = (cnt > SMX) ? SMX : cnt;
    sp = (sc >= MN) && (sc <= MX);
    checkVal({name, " valid"}, valid, 1);
    checkVal({name, " count_out"}, count_out, cnt);
    checkVal({name, " pass"}, pass, p);
    checkVal({name, " fail"}, fail, !p);
    checkVal({name, " led"}, led, l);
    checkVal({name, " sat valid"}, valid_s, 1);
    checkVal({name, " sat count"}, count_s, sc);
    checkVal({name, " sat pass"}, pass_s, sp);
    checkVal({name, " sat led"}, led_s, {!sp, sp});
    last_cnt  = cnt;
    last_pass = p;
    last_fail = !p;
  endtask

  // Waits out a window opened at edge `start`; valid must appear exactly G+1 edges later.
  task automatic measure(input string name, input int start, input int cnt_in, input bit use_model);
    bit early = 1'b0;
    int cnt;
    bit p;
    while (edge_n < start + G + 1) begin
      tick();
      if (edge_n < start + G + 1 && valid) early = 1'b1;
    end
    checkVal({name, " no early valid"}, early, 0);
    cnt = use_model ? modelCount(start) : cnt_in;
    p = (cnt >= MN) && (cnt <= MX);
    checkOutput(name, cnt, p, {!p, p});
  endtask

  task automatic applyStimulus(input int m, input int per);
    en = 1'b0;
    mode = m;
    period = (per > 0) ? per : 1;
    ph = 0;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic closeWindow(input string name);
    en = 1'b0;
    tick();
    checkVal({name, " valid one cycle"}, valid, 0);
    tick();
    tick();
  endtask

  initial begin
    int start;
    bit seen;
    tbl[0] = '{2, 10, 10, 1'b1, 2'b01};
    tbl[1] = '{0,  0,  0, 1'b0, 2'b10};
    tbl[2] = '{1,  0,  0, 1'b0, 2'b10};
    tbl[3] = '{2,  4, 25, 1'b0, 2'b10};
    tbl[4] = '{2, 10, 10, 1'b1, 2'b01};
    tbl[5] = '{2, 20,  5, 1'b0, 2'b10};
    tbl[6] = '{2,  5, 20, 1'b0, 2'b10};
    tbl[7] = '{2, 25,  4, 1'b0, 2'b10};

    rst = 1'b1;
    en = 1'b0;
    sig_in = 1'b0;
    tick();
    tick();
    checkVal("reset count_out", count_out, 0);
    checkVal("reset valid", valid, 0);
    checkVal("reset pass", pass, 0);
    checkVal("reset fail", fail, 0);
    checkVal("reset led", led, 0);
    rst = 1'b0;
    tick();
    tick();
    checkVal("idle no valid", valid, 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].mode, tbl[i].period);
      en = 1'b1;
      start = edge_n + 1;
      measure($sformatf("vec%0d", i), start, tbl[i].exp_cnt, 1'b0);
      checkVal($sformatf("vec%0d pass", i), pass, tbl[i].exp_pass);
      checkVal($sformatf("vec%0d led", i), led, tbl[i].exp_led);
      closeWindow($sformatf("vec%0d", i));
    end

    // Periods straddling the pass boundaries; exact count depends on phase.
    for (int i = 0; i < 4; i++) begin
      int pl [4] = '{8, 9, 11, 12};
      applyStimulus(2, pl[i]);
      en = 1'b1;
      start = edge_n + 1;
      measure($sformatf("bound p%0d", pl[i]), start, 0, 1'b1);
      closeWindow($sformatf("bound p%0d", pl[i]));
    end

    $display("[TB] back-to-back windows");
    applyStimulus(2, 10);
    en = 1'b1;
    start = edge_n + 1;
    measure("b2b first", start, 10, 1'b0);
    measure("b2b second", start + G + 1, 10, 1'b0);
    measure("b2b third", start + 2 * (G + 1), 10, 1'b0);
    closeWindow("b2b");

    $display("[TB] abort mid-window");
    applyStimulus(2, 4);
    en = 1'b1;
    start = edge_n + 1;
    measure("pre-abort", start, 25, 1'b0);
    closeWindow("pre-abort");
    applyStimulus(2, 10);
    en = 1'b1;
    start = edge_n + 1;
    while (edge_n < start + 50) tick();
    en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < G + 20; i++) begin
      tick();
      if (valid) seen = 1'b1;
    end
    checkVal("abort no valid", seen, 0);
    checkVal("abort hold count", count_out, last_cnt);
    checkVal("abort hold pass", pass, last_pass);
    checkVal("abort hold fail", fail, last_fail);
    en = 1'b1;
    start = edge_n + 1;
    measure("after abort", start, 10, 1'b0);
    closeWindow("after abort");

    $display("[TB] reset mid-window");
    en = 1'b1;
    start = edge_n + 1;
    while (edge_n < start + 40) tick();
    #2 rst = 1'b1;
    #1;
    checkVal("mid rst count_out", count_out, 0);
    checkVal("mid rst valid", valid, 0);
    checkVal("mid rst pass", pass, 0);
    checkVal("mid rst fail", fail, 0);
    checkVal("mid rst led", led, 0);
    checkVal("mid rst sat count", count_s, 0);
    en = 1'b0;
    tick();
    tick();
    #2 rst = 1'b0;
    tick();
    tick();
    checkVal("post rst idle", valid, 0);
    en = 1'b1;
    start = edge_n + 1;
    measure("after rst", start, 10, 1'b0);
    closeWindow("after rst");

    $display("[TB] random waveforms");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(3, 0);
      en = 1'b1;
      start = edge_n + 1;
      measure($sformatf("rand%0d", i), start, 0, 1'b1);
      closeWindow($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
